// File: rtl/router_pkt_tx.sv
// router_pkt_tx: packet transmitter for the 1x3 router input port.
//
// Accepts a destination/length command, then buffers the whole payload
// (up to 63 bytes). It then drives the router protocol: a header byte
// {len, addr}, the payload bytes, and an even-XOR parity byte. Each
// driven byte is held while busy=1 and consumed at an edge with busy=0.
//
// Ports:
//   clock, resetn        clock; synchronous active-high reset (asserted = 1)
//   cmd_valid/cmd_ready  command handshake; cmd_addr (0..2), cmd_len (0..63)
//   pl_valid/pl_ready    payload byte handshake; pl_data
//   busy                 router backpressure
//   pkt_valid, data_out  registered byte stream to the router
//   pkt_done             one-cycle pulse after the parity byte is consumed
//   cmd_err              one-cycle pulse when an addr=3 command is dropped
//   err_inject           only with ROUTER_PKT_TX_PARITY_CORRUPT_EN: sampled at
//                        the command handshake; 1 flips bit 0 of the parity byte
//
// Parameter GAP_CYCLES: idle cycles after parity before accepting a command.
module router_pkt_tx #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_addr,
  input  logic [5:0] cmd_len,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic [7:0] pl_data,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       pkt_done,
  output logic       cmd_err
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
  ,
  input  logic       err_inject
`endif
);

  typedef enum logic [2:0] {
    StIdle, StLoad, StHeader, StPayload, StParity, StGap
  } state_e;

  state_e      state_q;
  logic [1:0]  addr_q;
  logic [5:0]  len_q;
  logic [5:0]  wr_q;
  logic [5:0]  rd_q;
  logic [7:0]  parity_q;
  logic        corrupt_q;
  int unsigned gap_q;
  logic [7:0]  mem [64];

  logic       inj;
  logic       cmd_hs;
  logic       pl_hs;
  logic [7:0] hdr;
  logic [7:0] flip;

`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
  assign inj = err_inject;
`else
  assign inj = 1'b0;
`endif

  // Readies are decoded from state so they drop as soon as reset is asserted.
  assign cmd_ready = ~resetn & (state_q == StIdle);
  assign pl_ready  = ~resetn & (state_q == StLoad) & (wr_q != len_q);
  assign cmd_hs    = cmd_valid & cmd_ready;
  assign pl_hs     = pl_valid & pl_ready;
  assign hdr       = {len_q, addr_q};
  assign flip      = {7'b0, corrupt_q};

  // Payload storage; contents are don't-care after reset.
  always_ff @(posedge clock) begin
    if (pl_hs) begin
      mem[wr_q] <= pl_data;
    end
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      state_q   <= StIdle;
      pkt_valid <= 1'b0;
      data_out  <= 8'h00;
      pkt_done  <= 1'b0;
      cmd_err   <= 1'b0;
      addr_q    <= 2'd0;
      len_q     <= 6'd0;
      wr_q      <= 6'd0;
      rd_q      <= 6'd0;
      parity_q  <= 8'h00;
      corrupt_q <= 1'b0;
      gap_q     <= 0;
    end else begin
      pkt_done <= 1'b0;
      cmd_err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_hs) begin
            addr_q    <= cmd_addr;
            len_q     <= cmd_len;
            wr_q      <= 6'd0;
            rd_q      <= 6'd0;
            corrupt_q <= inj;
            if (cmd_addr == 2'd3) begin
              cmd_err <= 1'b1;
            end else begin
              state_q <= StLoad;
            end
          end
        end
        StLoad: begin
          // wr_q == len_q here only for a zero-length packet.
          if (wr_q == len_q) begin
            state_q   <= StHeader;
            pkt_valid <= 1'b1;
            data_out  <= hdr;
            parity_q  <= hdr;
          end else if (pl_hs) begin
            wr_q <= wr_q + 6'd1;
            if (wr_q + 6'd1 == len_q) begin
              state_q   <= StHeader;
              pkt_valid <= 1'b1;
              data_out  <= hdr;
              parity_q  <= hdr;
            end
          end
        end
        StHeader: begin
          if (!busy) begin
            if (len_q != 6'd0) begin
              state_q  <= StPayload;
              data_out <= mem[6'd0];
            end else begin
              state_q   <= StParity;
              pkt_valid <= 1'b0;
              data_out  <= parity_q ^ flip;
            end
          end
        end
        StPayload: begin
          if (!busy) begin
            parity_q <= parity_q ^ data_out;
            rd_q     <= rd_q + 6'd1;
            if (rd_q == len_q - 6'd1) begin
              state_q   <= StParity;
              pkt_valid <= 1'b0;
              data_out  <= parity_q ^ data_out ^ flip;
            end else begin
              data_out <= mem[rd_q + 6'd1];
            end
          end
        end
        StParity: begin
          if (!busy) begin
            pkt_done <= 1'b1;
            data_out <= 8'h00;
            gap_q    <= 0;
            state_q  <= (GAP_CYCLES == 0) ? StIdle : StGap;
          end
        end
        StGap: begin
          if (gap_q + 1 >= GAP_CYCLES) begin
            state_q <= StIdle;
          end else begin
            gap_q <= gap_q + 1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx with a scoreboard of expected router-side
// bytes {pkt_valid, data_out}, popped by a monitor whenever a byte is consumed.
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_addr = 2'd0;
  logic [5:0] cmd_len = 6'd0;
  logic       pl_valid = 1'b0;
  logic [7:0] pl_data = 8'h00;
  logic       busy = 1'b0;
  logic       cmd_ready, pl_ready, pkt_valid, pkt_done, cmd_err;
  logic [7:0] data_out;
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
  logic       err_inject = 1'b0;
`endif

  router_pkt_tx #(.GAP_CYCLES(1)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .pl_valid  (pl_valid),
    .pl_ready  (pl_ready),
    .pl_data   (pl_data),
    .busy      (busy),
    .pkt_valid (pkt_valid),
    .data_out  (data_out),
    .pkt_done  (pkt_done),
    .cmd_err   (cmd_err)
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
    ,
    .err_inject(err_inject)
`endif
  );

  always #5 clock = ~clock;

  int         tests = 0;
  int         fails = 0;
  logic [8:0] sb_q[$];
  logic [7:0] pay [64];
  logic       in_pkt = 1'b0;
  logic       exp_done = 1'b0;
  int         pl_cnt = 0;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic consume(input logic pv);
    logic [8:0] e;
    tests++;
    assert (sb_q.size() > 0) else begin
      fails++;
      $error("FAIL sb_empty: observed %h expected nothing", {pv, data_out});
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("stream", {pv, data_out}, e);
    end
  endtask

  // Monitor: a byte is consumed at an edge where busy is low; the byte after
  // the last pkt_valid byte is the parity byte.
  always @(negedge clock) begin
    if (pl_ready) pl_cnt <= pl_cnt + 1;
    if (resetn) begin
      in_pkt   <= 1'b0;
      exp_done <= 1'b0;
    end else begin
      check("pkt_done", {8'h00, pkt_done}, {8'h00, exp_done});
      exp_done <= 1'b0;
      if (pkt_valid) begin
        in_pkt <= 1'b1;
        if (!busy) consume(1'b1);
      end else if (in_pkt && !busy) begin
        consume(1'b0);
        in_pkt   <= 1'b0;
        exp_done <= 1'b1;
      end
    end
  end

  task automatic push_pkt(input logic [1:0] a, input logic [5:0] n, input logic inj);
    logic [7:0] p;
    p = {n, a};
    sb_q.push_back({1'b1, p});
    for (int i = 0; i < int'(n); i++) begin
      sb_q.push_back({1'b1, pay[i]});
      p = p ^ pay[i];
    end
    sb_q.push_back({1'b0, p ^ {7'b0, inj}});
  endtask

  task automatic send_cmd(input logic [1:0] a, input logic [5:0] n, input logic inj);
    int k;
    k = 0;
    while (!cmd_ready && k < 200) begin
      @(posedge clock); #1; k++;
    end
    check("cmd_ready_wait", {8'h00, cmd_ready}, 9'h001);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = n;
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
    err_inject = inj;
`else
    if (inj) $display("[TB] err_inject ignored without corrupt option");
`endif
    @(posedge clock); #1;
    cmd_valid = 1'b0;
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
    err_inject = 1'b0;
`endif
  endtask

  task automatic send_payload(input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      pl_valid = 1'b1;
      pl_data  = pay[i];
      k = 0;
      while (!pl_ready && k < 200) begin
        @(posedge clock); #1; k++;
      end
      check("pl_ready_wait", {8'h00, pl_ready}, 9'h001);
      @(posedge clock); #1;
    end
    pl_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!pkt_done && k < 300) begin
      @(posedge clock); #1; k++;
    end
    check("pkt_done_wait", {8'h00, pkt_done}, 9'h001);
  endtask

  initial begin
    int k;
    int snap;
    logic [7:0] exp_seq [4];

    // Reset values
    repeat (3) @(posedge clock);
    #1;
    check("rst_cmd_ready", {8'h00, cmd_ready}, 9'h000);
    check("rst_pl_ready",  {8'h00, pl_ready},  9'h000);
    check("rst_pkt_valid", {8'h00, pkt_valid}, 9'h000);
    check("rst_data_out",  {1'b0, data_out},   9'h000);
    check("rst_pkt_done",  {8'h00, pkt_done},  9'h000);
    check("rst_cmd_err",   {8'h00, cmd_err},   9'h000);
    resetn = 1'b0;
    #1;
    check("cmd_ready_after_rst", {8'h00, cmd_ready}, 9'h001);

    // addr=1 len=3, busy low: exact cycle-by-cycle stream
    pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
    exp_seq[0] = 8'hA1; exp_seq[1] = 8'hB2; exp_seq[2] = 8'hC3; exp_seq[3] = 8'hDD;
    push_pkt(2'd1, 6'd3, 1'b0);
    send_cmd(2'd1, 6'd3, 1'b0);
    send_payload(3);
    check("t1_header", {pkt_valid, data_out}, {1'b1, 8'h0D});
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      check("t1_seq", {pkt_valid, data_out}, {(i < 3), exp_seq[i]});
    end
    @(posedge clock); #1;
    check("t1_done", {8'h00, pkt_done}, 9'h001);
    check("t1_gap_ready", {8'h00, cmd_ready}, 9'h000);
    @(posedge clock); #1;
    check("t1_idle_ready", {8'h00, cmd_ready}, 9'h001);

    // Same packet, header held under busy for 3 extra cycles
    busy = 1'b1;
    push_pkt(2'd1, 6'd3, 1'b0);
    send_cmd(2'd1, 6'd3, 1'b0);
    send_payload(3);
    check("t2_header", {pkt_valid, data_out}, {1'b1, 8'h0D});
    repeat (3) begin
      @(posedge clock); #1;
      check("t2_hold", {pkt_valid, data_out}, {1'b1, 8'h0D});
    end
    busy = 1'b0;
    @(posedge clock); #1;
    check("t2_after_hold", {pkt_valid, data_out}, {1'b1, 8'hA1});
    wait_done();

    // addr=2 len=0: header and parity only, no payload request
    snap = pl_cnt;
    push_pkt(2'd2, 6'd0, 1'b0);
    send_cmd(2'd2, 6'd0, 1'b0);
    wait_done();
    tests++;
    assert (pl_cnt == snap) else begin
      fails++;
      $error("FAIL len0_pl_ready: observed %0d ready cycles expected 0", pl_cnt - snap);
    end

    // addr=3: dropped with cmd_err
    send_cmd(2'd3, 6'd5, 1'b0);
    check("t4_cmd_err", {8'h00, cmd_err}, 9'h001);
    check("t4_pkt_valid", {8'h00, pkt_valid}, 9'h000);
    @(posedge clock); #1;
    check("t4_cmd_err_clr", {8'h00, cmd_err}, 9'h000);
    check("t4_cmd_ready", {8'h00, cmd_ready}, 9'h001);
    check("t4_pkt_valid2", {8'h00, pkt_valid}, 9'h000);

    // Reset during the 2nd payload byte of a len=10 packet
    for (int i = 0; i < 10; i++) pay[i] = 8'(i * 16 + 7);
    push_pkt(2'd0, 6'd10, 1'b0);
    send_cmd(2'd0, 6'd10, 1'b0);
    send_payload(10);
    k = 0;
    while (!(pkt_valid && data_out === pay[1]) && k < 50) begin
      @(posedge clock); #1; k++;
    end
    check("t5_reach_byte2", {pkt_valid, data_out}, {1'b1, pay[1]});
    resetn = 1'b1;
    sb_q.delete();
    @(posedge clock); #1;
    check("t5_rst_pkt_valid", {8'h00, pkt_valid}, 9'h000);
    check("t5_rst_data_out", {1'b0, data_out}, 9'h000);
    check("t5_rst_cmd_ready", {8'h00, cmd_ready}, 9'h000);
    resetn = 1'b0;
    #1;
    check("t5_ready_after", {8'h00, cmd_ready}, 9'h001);
    pay[0] = 8'h3C;
    push_pkt(2'd0, 6'd1, 1'b0);
    send_cmd(2'd0, 6'd1, 1'b0);
    send_payload(1);
    check("t5_header", {pkt_valid, data_out}, {1'b1, 8'h04});
    wait_done();

    // Full-length packet
    for (int i = 0; i < 63; i++) pay[i] = 8'(i * 5 + 1);
    push_pkt(2'd2, 6'd63, 1'b0);
    send_cmd(2'd2, 6'd63, 1'b0);
    send_payload(63);
    check("t6_header", {pkt_valid, data_out}, {1'b1, 8'hFE});
    wait_done();

`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
    // Corrupted parity: 0x51 becomes 0x50
    pay[0] = 8'h55;
    push_pkt(2'd0, 6'd1, 1'b1);
    send_cmd(2'd0, 6'd1, 1'b1);
    send_payload(1);
    wait_done();
`endif

    repeat (4) @(posedge clock);
    #1;
    tests++;
    assert (sb_q.size() == 0) else begin
      fails++;
      $error("FAIL sb_drain: observed %0d pending expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet transmitter for the 1x3 router's input port. It accepts a destination/length command and a byte stream of payload, and buffers the full payload internally. It then drives the router's `pkt_valid`/data/`busy` protocol: header byte, payload bytes, then an even-XOR parity byte. It stalls on `busy` and never starves mid-packet. It sits between a host/traffic source and `router_top`, and is also the standard stimulus driver for system benches.

## Interface
- `GAP_CYCLES`, 1, idle cycles forced after a parity byte is accepted before `cmd_ready` rises again (0 allowed)
- `clock`  in  1  single clock; all logic on rising edge
- `resetn`  in  1  reset; synchronous and active-high (asserted = 1 despite the name)
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`
- `cmd_addr`  in  2  destination port 0..2; 3 is illegal
- `cmd_len`  in  6  payload byte count 0..63
- `pl_valid`  in  1  payload byte valid
- `pl_ready`  out  1  payload byte accepted when `pl_valid & pl_ready`
- `pl_data`  in  8  payload byte
- `busy`  in  1  router backpressure; a driven byte is consumed at an edge where `busy`=0
- `pkt_valid`  out  1  to router; high during header and payload bytes
- `data_out`  out  8  to router `data_in`
- `pkt_done`  out  1  one-cycle pulse after parity byte is consumed
- `cmd_err`  out  1  one-cycle pulse when an illegal command is dropped
- `err_inject`  in  1  present only with `ROUTER_PKT_TX_PARITY_CORRUPT_EN`

## Operation
- Internal 64x8 payload buffer, 6-bit write index, 6-bit read index, 8-bit running parity register.
- States: IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP.
- IDLE: `cmd_ready`=1. On handshake, latch addr/len and clear the indices.
  - If addr=3: pulse `cmd_err` next cycle and stay IDLE. No packet is sent.
  - Otherwise: go to LOAD.
- LOAD: `pl_ready`=1 while write index < len. Each handshake stores a byte and increments the write index. When index == len (immediately if len=0), go to HEADER.
- HEADER: `data_out`={len,addr}, `pkt_valid`=1. Parity is loaded with the header value.
  - Edge with `busy`=0 and len>0: go to PAYLOAD.
  - Edge with `busy`=0 and len=0: go to PARITY.
- PAYLOAD: `data_out`=buf[rd], `pkt_valid`=1. On an edge with `busy`=0, XOR the byte into parity and increment rd. After byte len-1 is consumed, go to PARITY.
- PARITY: `pkt_valid`=0, `data_out`=parity. On an edge with `busy`=0, pulse `pkt_done` and go to GAP (or IDLE if `GAP_CYCLES`=0).
- GAP: count `GAP_CYCLES` cycles, then go to IDLE.
- `data_out` and `pkt_valid` are registered. They change only on consumption edges or state entry, and are held stable while `busy`=1.
- `cmd_valid` outside IDLE and `pl_valid` outside LOAD are ignored (ready low).

## Timing
- Reset values: `cmd_ready`=0, `pl_ready`=0, `pkt_valid`=0, `data_out`=0x00, `pkt_done`=0, `cmd_err`=0, state IDLE.
- `cmd_ready` is 1 in the first cycle after reset deasserts.
- Cmd handshake at edge T means LOAD from T+1. The last payload handshake at edge L means HEADER is driven from L+1.
- With `busy` held low, an N-byte payload occupies exactly N+2 consecutive cycles on the router side (header, N payload, parity). `pkt_done` is high in the cycle after parity is consumed.
- Reset asserted in any state: at the next edge return to IDLE with reset values. A partial packet is abandoned (`pkt_valid` drops) and buffer contents are don't-care.
- `busy` going high at any point, including on the header or parity, freezes the current byte indefinitely. There is no timeout.
- Full length 63 is legal: the write index reaches 63 without wrap, and rd ends at 63.

## Configuration
- `ROUTER_PKT_TX_PARITY_CORRUPT_EN` defined:
  - Port `err_inject` exists. It is sampled at the cmd handshake.
  - If it was 1, the driven parity byte is bit-0-inverted, for router `error` testing.
- Not defined: the port is absent and parity is always correct.

## Test plan
- addr=1, len=3, payload A1,B2,C3, busy=0 -> `data_out` 0x0D,0xA1,0xB2,0xC3 with `pkt_valid`=1, then 0xDD with `pkt_valid`=0; `pkt_done` pulses the next cycle.
- Same packet, `busy`=1 for 3 cycles while header is driven -> 0x0D held 4 cycles, then the sequence continues unchanged.
- addr=2, len=0 -> header 0x02 then parity 0x02; `pl_ready` never asserts.
- addr=3, len=5 -> `cmd_err` pulses once, `pkt_valid` stays 0, `cmd_ready` returns high.
- Reset asserted during the 2nd payload byte of a len=10 packet -> next cycle `pkt_valid`=0, `data_out`=0x00. A following addr=0 len=1 packet is sent correctly.
- With the macro, `err_inject`=1, addr=0, len=1, payload 0x55 -> parity byte 0x50 instead of 0x51.
